// File: rtl/datapath_arbiter.sv
// Round-robin arbiter feeding one shared datapath, one transaction in flight at a time; accept T, dp_en T+1, rsp_valid T+3 at the earliest.
// A response is held until rsp_ready is high, and no request is accepted until the arbiter is back in IDLE.
module datapath_arbiter #(
   parameter int DATA_WIDTH = 5,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   output logic [DATA_WIDTH-1:0] dp_data_in,
   output logic                  dp_en,
   input  logic                  dp_done,
   input  logic [DATA_WIDTH-1:0] dp_data_out,
   output logic                  rsp_valid,
   output logic                  rsp_id,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   input  logic                  rsp_ready
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t                r_state;
   state_t                w_next;
   logic                  r_last_grant;
   logic [7:0]            r_cnt;
   logic [DATA_WIDTH-1:0] r_op;
   logic                  r_id;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                  r_rsp_err;
   logic                  w_gnt0;
   logic                  w_gnt1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      case (r_state)
         S_IDLE: begin
            // On a tie the requester that did not win last time is granted.
            w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
            w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
            if (w_gnt0 || w_gnt1) w_next = S_ISSUE;
         end
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (dp_done || r_cnt == CNT_LAST) w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
         r_op         <= '0;
         r_id         <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt0 || w_gnt1) begin
                  r_op         <= w_gnt1 ? req1_data : req0_data;
                  r_id         <= w_gnt1;
                  r_last_grant <= w_gnt1;
                  r_cnt        <= '0;
               end
            end
            S_WAIT: begin
               // A completion on the last counted cycle beats the timeout.
               if (dp_done) begin
                  r_rsp_data <= dp_data_out;
                  r_rsp_err  <= 1'b0;
               end else if (r_cnt == CNT_LAST) begin
                  r_rsp_data <= '1;
                  r_rsp_err  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req0_ready = rst && w_gnt0;
   assign req1_ready = rst && w_gnt1;
   assign dp_en      = (r_state == S_ISSUE);
   assign dp_data_in = r_op;
   assign rsp_valid  = (r_state == S_RESP);
   assign rsp_id     = r_id;
   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_datapath_arbiter.sv
// Randomized bench for datapath_arbiter against a transaction-level model of grant order, latency and response contents.
module tb_datapath_arbiter;

   localparam int DW = 5;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [DW-1:0] req0_data, req1_data;
   logic [DW-1:0] dp_data_in, dp_data_out, rsp_data;
   logic          dp_en, dp_done, rsp_valid, rsp_id, rsp_err, rsp_ready;

   int n_checks = 0;
   int n_errors = 0;

   bit            m_last;
   bit            pend [2];
   logic [DW-1:0] pdat [2];

   datapath_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .dp_data_in(dp_data_in), .dp_en(dp_en), .dp_done(dp_done), .dp_data_out(dp_data_out),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .rsp_ready(rsp_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_reqs();
      req0_valid = pend[0];
      req1_valid = pend[1];
      req0_data  = pdat[0];
      req1_data  = pdat[1];
   endtask

   // mode: 0 random refill, 1 force both pending, 2 use pending set as-is.
   // d: WAIT cycle index of dp_done (>= TO means never, <0 random); dd: done data (<0 random).
   task automatic run_txn(input int d_sel, input int h_sel, input int mode, input int dd);
      int            win, d, h;
      logic [DW-1:0] op, exp_data;
      bit            exp_err;
      if (mode != 2)
         for (int i = 0; i < 2; i++)
            if (!pend[i] && (mode == 1 || $urandom_range(0, 1) == 1)) begin
               pend[i] = 1'b1;
               pdat[i] = DW'($urandom);
            end
      if (!pend[0] && !pend[1]) begin
         win       = $urandom_range(0, 1);
         pend[win] = 1'b1;
         pdat[win] = DW'($urandom);
      end
      win      = (pend[0] && pend[1]) ? (m_last ? 0 : 1) : (pend[1] ? 1 : 0);
      d        = (d_sel >= 0) ? d_sel : $urandom_range(0, TO + 2);
      h        = (h_sel >= 0) ? h_sel : $urandom_range(0, 3);
      exp_data = '0;
      exp_err  = 1'b0;

      @(negedge clk);
      drive_reqs();
      rsp_ready   = 1'($urandom);
      dp_done     = 1'($urandom);
      dp_data_out = DW'($urandom);
      #1;
      chk("idle_ready0", 32'(req0_ready), 32'(win == 0));
      chk("idle_ready1", 32'(req1_ready), 32'(win == 1));
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_dp_en", 32'(dp_en), 32'd0);
      op        = pdat[win];
      pend[win] = 1'b0;
      m_last    = (win == 1);

      @(negedge clk);
      drive_reqs();
      dp_done     = 1'($urandom);
      dp_data_out = DW'($urandom);
      #1;
      chk("issue_dp_en", 32'(dp_en), 32'd1);
      chk("issue_dp_in", 32'(dp_data_in), 32'(op));
      chk("issue_ready", 32'({req1_ready, req0_ready}), 32'd0);

      for (int k = 0; k < TO; k++) begin
         @(negedge clk);
         dp_done     = (k == d);
         dp_data_out = (dd >= 0 && k == d) ? DW'(dd) : DW'($urandom);
         #1;
         chk("wait_dp_en", 32'(dp_en), 32'd0);
         chk("wait_dp_in", 32'(dp_data_in), 32'(op));
         chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("wait_ready", 32'({req1_ready, req0_ready}), 32'd0);
         if (k == d) begin
            exp_data = dp_data_out;
            exp_err  = 1'b0;
            break;
         end
         if (k == TO - 1) begin
            exp_data = '1;
            exp_err  = 1'b1;
         end
      end

      for (int j = 0; j <= h; j++) begin
         @(negedge clk);
         rsp_ready   = (j == h);
         dp_done     = 1'($urandom);
         dp_data_out = DW'($urandom);
         #1;
         chk("rsp_valid", 32'(rsp_valid), 32'd1);
         chk("rsp_id", 32'(rsp_id), 32'(win));
         chk("rsp_data", 32'(rsp_data), 32'(exp_data));
         chk("rsp_err", 32'(rsp_err), 32'(exp_err));
         chk("rsp_ready_blk", 32'({req1_ready, req0_ready}), 32'd0);
         chk("rsp_dp_en", 32'(dp_en), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
      dp_done = 1'b0; dp_data_out = '0; rsp_ready = 1'b0;
      m_last = 1'b1;
      pend[0] = 1'b0; pend[1] = 1'b0; pdat[0] = '0; pdat[1] = '0;
      #12;
      chk("rst_outputs", 32'({req0_ready, req1_ready, dp_en, dp_data_in, rsp_valid, rsp_id, rsp_data, rsp_err}), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Tie straight out of reset, then the loser is served next.
      pend[0] = 1'b1; pdat[0] = 5'h03; pend[1] = 1'b1; pdat[1] = 5'h0A;
      run_txn(1, 0, 2, -1);
      run_txn(1, 0, 2, -1);

      // Lone requester 1 at minimum latency.
      pend[0] = 1'b0; pend[1] = 1'b1; pdat[1] = 5'h07;
      run_txn(0, 0, 2, 5'h11);

      run_txn(TO + 5, 0, 0, -1);  // timeout
      run_txn(TO - 1, 0, 0, -1);  // completion on the final WAIT cycle
      run_txn(-1, 10, 0, -1);     // long backpressure

      // Abort during WAIT with an asynchronous reset.
      pend[0] = 1'b0; pend[1] = 1'b1; pdat[1] = 5'h15;
      @(negedge clk);
      drive_reqs(); rsp_ready = 1'b0; dp_done = 1'b0;
      @(negedge clk);
      pend[1] = 1'b0; drive_reqs();
      repeat (4) @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1 rst = 1'b0;
      #1;
      chk("abort_outputs", 32'({req0_ready, req1_ready, dp_en, dp_data_in, rsp_valid, rsp_id, rsp_data, rsp_err}), 32'd0);
      m_last = 1'b1;
      @(negedge clk);
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      dp_done = 1'b1; dp_data_out = 5'h1A;
      #1;
      chk("late_done_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("late_done_ready", 32'({req1_ready, req0_ready}), 32'd0);
      run_txn(-1, -1, 1, -1);     // first tie after reset goes to requester 0

      for (int n = 0; n < 200; n++) run_txn(-1, -1, 0, -1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/datapath_arbiter.md
DATAPATH_ARBITER -- requirements
Module: datapath_arbiter

Interface
REQ-001: Parameter DATA_WIDTH, default 5, SHALL set the request/response data width.
REQ-002: Parameter TIMEOUT, default 15, SHALL set the max WAIT cycles before abort; legal range 1..255.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004: rst  input  1  SHALL be the reset, asynchronous assert, active-low.
REQ-005: req0_valid  input  1  requester 0 has a transaction.
REQ-006: req0_data  input  DATA_WIDTH  requester 0 operand.
REQ-007: req0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-008: req1_valid / req1_data / req1_ready SHALL mirror REQ-005..007 for requester 1.
REQ-009: dp_data_in  output  DATA_WIDTH  operand to shared datapath.
REQ-010: dp_en  output  1  one-cycle start pulse to datapath.
REQ-011: dp_done  input  1  datapath result valid.
REQ-012: dp_data_out  input  DATA_WIDTH  datapath result.
REQ-013: rsp_valid  output  1  response pending.
REQ-014: rsp_id  output  1  requester owning the response.
REQ-015: rsp_data  output  DATA_WIDTH  result.
REQ-016: rsp_err  output  1  response produced by timeout.
REQ-017: rsp_ready  input  1  response consumer accepts.

Function
REQ-018: FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-019: In IDLE, grant SHALL be round-robin: if both valid, requester != last_grant wins; if one valid, it wins.
REQ-020: reqN_ready SHALL be high only in IDLE for the granted requester with reqN_valid high; combinational from state, last_grant, valids.
REQ-021: On valid&ready, operand and id SHALL be captured, last_grant updated, IDLE->ISSUE.
REQ-022: ISSUE SHALL last exactly one cycle with dp_en=1, dp_data_in=captured operand; ->WAIT.
REQ-023: dp_data_in SHALL hold the captured operand from ISSUE until leaving WAIT.
REQ-024: WAIT SHALL count cycles from 0; dp_done=1 captures dp_data_out, rsp_err=0, ->RESP.
REQ-025: If count reaches TIMEOUT-1 with dp_done=0, rsp_data SHALL be all ones, rsp_err=1, ->RESP.
REQ-026: dp_done and timeout in the same cycle: dp_done SHALL win (rsp_err=0).
REQ-027: dp_done outside WAIT SHALL be ignored.
REQ-028: In RESP, rsp_valid=1 with rsp_id/rsp_data/rsp_err stable until rsp_ready=1; then ->IDLE next cycle.
REQ-029: Minimum latency: accept cycle T, dp_en at T+1, dp_done at T+2 earliest, rsp_valid at T+3.
REQ-030: No new request SHALL be accepted before returning to IDLE (no accept in RESP exit cycle).

Reset
REQ-031: rst low SHALL force state IDLE, last_grant=1 (requester 0 wins first tie), counter 0.
REQ-032: Reset values: req0_ready=0, req1_ready=0, dp_en=0, dp_data_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
REQ-033: Reset mid-transaction SHALL abort it with no response; first post-reset tie goes to requester 0.

Verification
REQ-034: Both valid from reset, data 5'h03/5'h0A, dp_done 2 cycles after dp_en -> req0 served first (rsp_id=0), then req1 (rsp_id=1).
REQ-035: Only req1 valid, dp_done at T+2 with 5'h11 -> rsp_valid at T+3, rsp_id=1, rsp_data=5'h11, rsp_err=0.
REQ-036: dp_done never asserted, TIMEOUT=15 -> rsp_valid after 15 WAIT cycles, rsp_data=5'h1F, rsp_err=1.
REQ-037: dp_done on final WAIT cycle (count=14) -> rsp_err=0, rsp_data = dp_data_out.
REQ-038: rsp_ready held low 10 cycles -> rsp_* stable, both reqN_ready stay 0; release -> IDLE next cycle.
REQ-039: rst pulsed low during WAIT -> all outputs to reset values immediately; late dp_done ignored.
